// File: rtl/hamming_secded_reg.sv
// SECDED-protected shift/load register: each data nibble carries p1,p2,p3,p0 check bits.
// Outputs are corrected with zero latency, single errors are scrubbed back, and error statistics are kept.
module hamming_secded_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     load,
  input  logic                     serial_in,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         parallel_in,
  input  logic                     inject_en,
  input  logic [WIDTH-1:0]         inject_data,
  input  logic [4*(WIDTH/4)-1:0]   inject_chk,
  input  logic                     clr_status,
  output logic                     serial_out,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     ce_pulse,
  output logic                     ue_flag,
  output logic [CNT_W-1:0]         ce_count,
  output logic [CNT_W-1:0]         ue_count
);
  localparam int BLOCKS = WIDTH / 4;

  logic [WIDTH-1:0]      data_q;
  logic [4*BLOCKS-1:0]   chk_q;
  logic [WIDTH-1:0]      view;
  logic [4*BLOCKS-1:0]   chk_fix;
  logic [WIDTH-1:0]      next_data;
  logic [4*BLOCKS-1:0]   next_chk;
  logic [BLOCKS-1:0]     ce_blk;
  logic [BLOCKS-1:0]     ue_blk;
  logic                  ce_now;
  logic                  ue_now;
  logic                  ue_prev;

  // Check nibble layout is {p0, p3, p2, p1}.
  function automatic logic [3:0] encode(input logic [3:0] n);
    logic p1, p2, p3;
    p1 = n[0] ^ n[2] ^ n[3];
    p2 = n[0] ^ n[1] ^ n[3];
    p3 = n[0] ^ n[1] ^ n[2];
    return {(^n) ^ p1 ^ p2 ^ p3, p3, p2, p1};
  endfunction

  always_comb begin
    logic [3:0] nib;
    logic [3:0] cb;
    logic [2:0] s;
    logic       q;
    view    = data_q;
    chk_fix = chk_q;
    ce_blk  = '0;
    ue_blk  = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      nib = data_q[4*i +: 4];
      cb  = chk_q[4*i +: 4];
      s   = {cb[2] ^ nib[2] ^ nib[1] ^ nib[0],
             cb[1] ^ nib[3] ^ nib[1] ^ nib[0],
             cb[0] ^ nib[3] ^ nib[2] ^ nib[0]};
      q   = ^{nib, cb};
      if (q) begin
        ce_blk[i] = 1'b1;
        case (s)
          3'b101: nib[2] = ~nib[2];
          3'b111: nib[0] = ~nib[0];
          3'b011: nib[3] = ~nib[3];
          3'b110: nib[1] = ~nib[1];
          3'b001: cb[0]  = ~cb[0];
          3'b010: cb[1]  = ~cb[1];
          3'b100: cb[2]  = ~cb[2];
          3'b000: cb[3]  = ~cb[3];
        endcase
      end else if (s != 3'b000) begin
        // Double error: leave the raw bits untouched rather than miscorrect.
        ue_blk[i] = 1'b1;
      end
      view[4*i +: 4]    = nib;
      chk_fix[4*i +: 4] = cb;
    end
  end

  assign ce_now       = |ce_blk;
  assign ue_now       = |ue_blk;
  assign parallel_out = view;
  assign serial_out   = (mode == 2'b00 || mode == 2'b10) ? view[0] : view[WIDTH-1];

  always_comb begin
    case (mode)
      2'b00:   next_data = {serial_in, view[WIDTH-1:1]};
      2'b01:   next_data = {view[WIDTH-2:0], serial_in};
      2'b10:   next_data = load ? parallel_in : {1'b0, view[WIDTH-1:1]};
      default: next_data = load ? parallel_in : view;
    endcase
    next_chk = '0;
    for (int i = 0; i < BLOCKS; i++)
      next_chk[4*i +: 4] = encode(next_data[4*i +: 4]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      chk_q    <= '0;
      ce_pulse <= 1'b0;
      ue_flag  <= 1'b0;
      ue_prev  <= 1'b0;
      ce_count <= '0;
      ue_count <= '0;
    end else begin
      if (enable) begin
        data_q <= next_data;
        chk_q  <= next_chk;
      end else if (inject_en) begin
        data_q <= data_q ^ inject_data;
        chk_q  <= chk_q ^ inject_chk;
      end else if (ce_now) begin
        data_q <= view;
        chk_q  <= chk_fix;
      end

      ce_pulse <= ce_now;
      ue_prev  <= ue_now;

      if (clr_status) begin
        ce_count <= '0;
        ue_count <= '0;
        ue_flag  <= 1'b0;
      end else begin
        if (ce_now && ce_count != {CNT_W{1'b1}})
          ce_count <= ce_count + CNT_W'(1);
        if (ue_now && !ue_prev && ue_count != {CNT_W{1'b1}})
          ue_count <= ue_count + CNT_W'(1);
        if (ue_now)
          ue_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hamming_secded_reg.sv
// Directed bench for hamming_secded_reg: hand-computed vectors on an 8-bit instance
// plus a CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_hamming_secded_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable, load, serial_in, inject_en, clr_status;
  logic [1:0] mode;
  logic [7:0] parallel_in, inject_data, inject_chk;

  logic       serial_out, ce_pulse, ue_flag;
  logic [7:0] parallel_out, ce_count, ue_count;
  logic       serial_out2, ce_pulse2, ue_flag2;
  logic [7:0] parallel_out2;
  logic [1:0] ce_count2, ue_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hamming_secded_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .serial_in(serial_in),
    .mode(mode), .parallel_in(parallel_in), .inject_en(inject_en),
    .inject_data(inject_data), .inject_chk(inject_chk), .clr_status(clr_status),
    .serial_out(serial_out), .parallel_out(parallel_out), .ce_pulse(ce_pulse),
    .ue_flag(ue_flag), .ce_count(ce_count), .ue_count(ue_count)
  );

  hamming_secded_reg #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .serial_in(serial_in),
    .mode(mode), .parallel_in(parallel_in), .inject_en(inject_en),
    .inject_data(inject_data), .inject_chk(inject_chk), .clr_status(clr_status),
    .serial_out(serial_out2), .parallel_out(parallel_out2), .ce_pulse(ce_pulse2),
    .ue_flag(ue_flag2), .ce_count(ce_count2), .ue_count(ue_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic inject(input logic [7:0] dm, input logic [7:0] cm);
    inject_en = 1'b1; inject_data = dm; inject_chk = cm;
    cyc();
    inject_en = 1'b0; inject_data = '0; inject_chk = '0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; load = 1'b0; serial_in = 1'b0; mode = 2'b11;
    parallel_in = '0; inject_en = 1'b0; inject_data = '0; inject_chk = '0;
    clr_status = 1'b0;
    #12;
    check("rst_pout", parallel_out, 8'h00);
    check("rst_sout", serial_out, 1'b0);
    check("rst_ce_cnt", ce_count, 8'h00);
    check("rst_ue_cnt", ue_count, 8'h00);
    check("rst_ue_flag", ue_flag, 1'b0);
    check("rst_ce_pulse", ce_pulse, 1'b0);
    rst = 1'b1;
    cyc();

    // PIPO load of A5
    mode = 2'b11; load = 1'b1; enable = 1'b1; parallel_in = 8'hA5;
    cyc();
    enable = 1'b0; load = 1'b0;
    check("load_pout", parallel_out, 8'hA5);
    check("load_chk", dut.chk_q, 8'h5A);
    check("load_ce_pulse", ce_pulse, 1'b0);

    // Single data-bit error on d2 of block 0
    inject(8'h04, 8'h00);
    check("ce_d2_pout", parallel_out, 8'hA5);
    check("ce_d2_raw", dut.data_q, 8'hA1);
    check("ce_d2_cnt_pre", ce_count, 8'h00);
    cyc();
    check("scrub_d2_raw", dut.data_q, 8'hA5);
    check("scrub_d2_cnt", ce_count, 8'h01);
    check("scrub_d2_pulse", ce_pulse, 1'b1);
    cyc();
    check("scrub_d2_pulse_off", ce_pulse, 1'b0);
    check("scrub_d2_cnt_hold", ce_count, 8'h01);

    // Single check-bit error on p0 of block 0
    inject(8'h00, 8'h08);
    check("ce_p0_chk_raw", dut.chk_q, 8'h52);
    check("ce_p0_pout", parallel_out, 8'hA5);
    cyc();
    check("scrub_p0_chk", dut.chk_q, 8'h5A);
    check("scrub_p0_cnt", ce_count, 8'h02);

    // Double error: pass through raw, count onset once
    inject(8'h06, 8'h00);
    check("ue_pout", parallel_out, 8'hA3);
    cyc();
    check("ue_flag_set", ue_flag, 1'b1);
    check("ue_cnt_1", ue_count, 8'h01);
    check("ue_no_ce", ce_count, 8'h02);
    repeat (10) cyc();
    check("ue_cnt_persist", ue_count, 8'h01);
    check("ue_pout_persist", parallel_out, 8'hA3);
    clr_status = 1'b1;
    cyc();
    check("clr_ce_cnt", ce_count, 8'h00);
    check("clr_ue_cnt", ue_count, 8'h00);
    check("clr_ue_flag", ue_flag, 1'b0);
    mode = 2'b11; load = 1'b1; enable = 1'b1; parallel_in = 8'hA5;
    cyc();
    enable = 1'b0; load = 1'b0; clr_status = 1'b0;
    cyc();
    check("reload_ue_flag", ue_flag, 1'b0);
    check("reload_chk", dut.chk_q, 8'h5A);

    // Shift right with a pending CE on d0
    inject(8'h01, 8'h00);
    mode = 2'b00; enable = 1'b1; serial_in = 1'b1;
    cyc();
    enable = 1'b0; serial_in = 1'b0;
    check("shift_pout", parallel_out, 8'hD2);
    check("shift_chk", dut.chk_q, 8'h1E);
    check("shift_ce_cnt", ce_count, 8'h01);
    check("shift_ce_pulse", ce_pulse, 1'b1);
    check("shift_sout_m00", serial_out, 1'b0);
    cyc();
    check("shift_no_resid", ce_pulse, 1'b0);
    check("shift_ce_cnt_hold", ce_count, 8'h01);
    mode = 2'b11;
    #1;
    check("sout_m11", serial_out, 1'b1);

    // Saturation on the 2-bit counter instance
    clr_status = 1'b1;
    cyc();
    clr_status = 1'b0;
    for (int k = 0; k < 5; k++) begin
      inject(8'h01 << k, 8'h00);
      cyc();
    end
    check("sat_cnt2", ce_count2, 2'd3);
    check("sat_cnt8", ce_count, 8'h05);
    check("sat_pout", parallel_out, 8'hD2);

    // Asynchronous reset while a scrub is pending
    inject(8'h10, 8'h00);
    #2 rst = 1'b0;
    #1;
    check("arst_pout", parallel_out, 8'h00);
    check("arst_chk", dut.chk_q, 8'h00);
    check("arst_ce_cnt", ce_count, 8'h00);
    check("arst_ce_cnt2", ce_count2, 2'd0);
    check("arst_ce_pulse", ce_pulse, 1'b0);
    check("arst_ue_flag", ue_flag, 1'b0);
    check("arst_sout", serial_out, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    check("post_rst_pout", parallel_out, 8'h00);
    check("post_rst_ce_cnt", ce_count, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hamming_secded_reg.md
# hamming_secded_reg

Parametrised shift/load register in which every 4-bit data nibble carries four SECDED check bits (the three Hamming check bits plus an overall parity bit). The block corrects single-bit errors on its outputs, scrubs the corrected value back into storage, and detects double-bit errors without miscorrecting them. Saturating error counters, a sticky uncorrectable-error flag and a fault-injection port support fault-tolerance characterisation. It sits wherever the design needs a protected SISO/PISO/PIPO register with observable error statistics.

## Interface
- WIDTH, 8: data width; must be a multiple of 4 and ≥ 4. Derived BLOCKS = WIDTH/4.
- CNT_W, 8: width of each error counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  shift/load enable.
- load  in  1  parallel load in modes 2'b10 and 2'b11.
- serial_in  in  1  serial data input.
- mode  in  2  00 SISO right, 01 SISO left, 10 PISO (right, zero fill), 11 PIPO.
- parallel_in  in  WIDTH  parallel load data.
- inject_en  in  1  fault-injection strobe.
- inject_data  in  WIDTH  XOR mask applied to stored data bits.
- inject_chk  in  4*BLOCKS  XOR mask applied to stored check bits.
- clr_status  in  1  clears counters and the sticky flag.
- serial_out  out  1  bit 0 of the corrected view in modes 00 and 10; bit WIDTH-1 otherwise.
- parallel_out  out  WIDTH  corrected view of stored data (combinational).
- ce_pulse  out  1  registered; high for one cycle after each cycle in which a correctable error was present.
- ue_flag  out  1  sticky uncorrectable-error flag.
- ce_count  out  CNT_W  saturating count of correctable-error cycles.
- ue_count  out  CNT_W  saturating count of uncorrectable-error onsets.

## Operation
- Storage: data d[WIDTH-1:0]; check bits c[4*BLOCKS-1:0]. For block i: c[4i+0]=p1, c[4i+1]=p2, c[4i+2]=p3, c[4i+3]=p0.
- Encoding for nibble d0..d3:
  - p1 = d0^d2^d3; p2 = d0^d1^d3; p3 = d0^d1^d2.
  - p0 = XOR of d0..d3 and p1..p3, giving even parity over all 8 bits.
- Syndrome per block: s0 = p1^d3^d2^d0; s1 = p2^d3^d1^d0; s2 = p3^d2^d1^d0; q = XOR of all 8 stored bits.
- Classification per block:
  - s=0, q=0: clean.
  - q=1: single error (CE). s=101 flips d2, 111 flips d0, 011 flips d3, 110 flips d1, 001 flips p1, 010 flips p2, 100 flips p3, 000 flips p0.
  - s≠0, q=0: double error (UE). No bit is altered.
- Corrected view: stored data with CE blocks repaired and UE blocks passed through raw. parallel_out, serial_out and the shift/load datapath all use the corrected view.
- Register update priority, highest first:
  - enable: next = f(mode, corrected view) using the same shift/load rules as the existing shift register. All check bits are recomputed from the next data, so any UE block is re-encoded as clean.
  - inject_en: d ^= inject_data; c ^= inject_chk.
  - any CE: write back corrected data and check bits (scrub).
  - otherwise: hold.
- ce_now = any block CE; ue_now = any block UE.
- ce_count increments in each cycle with ce_now=1.
- ue_count increments on the cycle ue_now rises (ue_now=1 and its registered value 0).
- ue_flag sets on ue_now and stays set until clr_status.
- Both counters saturate at 2^CNT_W-1.
- clr_status zeroes both counters and ue_flag, and overrides any increment in the same cycle.
- ce_pulse <= ce_now.

## Timing
- Reset (rst=0, asynchronous) clears d, c, both counters, ue_flag, ce_pulse and the ue_now history. All outputs are 0, which is a valid clean codeword.
- Reset asserted mid-shift or mid-scrub discards the operation immediately.
- parallel_out and serial_out show corrected data in the same cycle an error appears. Zero-cycle correction latency.
- A scrub commits at the first edge after a CE is present with enable=0 and inject_en=0. ce_pulse and ce_count reflect the CE one edge after it was seen.
- A CE held under continuous inject_en is not scrubbed, and ce_count increments every such cycle.
- Simultaneous enable and CE: the shift uses corrected data and the CE counts once. No separate scrub cycle follows.
- A UE that persists across multiple cycles increments ue_count only once.

## Test plan
- Reset, then mode 11, load=1, enable=1, parallel_in=8'hA5 -> parallel_out=8'hA5 and stored check bits equal 8'h5A.
- With 8'hA5 stored, inject_data=8'h04 for one cycle -> parallel_out stays 8'hA5. The next edge scrubs storage, ce_count=1 and ce_pulse is high for one cycle.
- With 8'hA5 stored, inject_chk=8'h08 (p0 of block 0) -> data unchanged, scrub restores check bits 8'h5A, ce_count increments by 1.
- With 8'hA5 stored, inject_data=8'h06 -> parallel_out=8'hA3 and ue_flag=1. ue_count=1 and stays 1 over 10 idle cycles. clr_status then zeroes the counters and the flag.
- Mode 00, 8'hA5 stored, inject_data=8'h01, then one enable cycle with serial_in=1 -> parallel_out=8'hD2, no residual error, ce_count=1.
- CNT_W=2, 5 separate single-bit injections -> ce_count saturates at 3. An assertion of rst mid-sequence clears all outputs to 0.
